// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Multiplexed 7-segment display scanner. It has a free-running slot and digit
//   scan, and a shadow buffer that moves to the active set only at the top of
//   each frame. Each slot begins with an anti-ghosting guard, and there are
//   per-digit blank, blink and decimal-point masks. A mode input overrides the
//   display with PASS, lockout dashes, or an off state.
//
// Ports
//   CLK          : only clock, rising edge
//   RST_N        : synchronous active-low reset
//   load         : one-cycle strobe, captures data and masks into the shadow buffer
//   data         : 4*DIGITS digit codes, nibble i drives digit i
//   blank_mask   : per-digit blank enable
//   blink_mask   : per-digit blink enable
//   dp_mask      : per-digit decimal point
//   mode         : 00 normal, 01 PASS, 10 lockout, 11 off (unbuffered)
//   ready        : high when no shadow transfer is pending
//   frame_start  : one-cycle pulse at the start of digit 0's slot
//   seg          : active-high segments, bit7 = decimal point (registered)
//   cs           : active-low digit selects (registered)
module seg7_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD     = 16,
  parameter int BLINK_DIV = 125
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [1:0]            mode,
  output logic                  ready,
  output logic                  frame_start,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     cs
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [1:0] MODE_NORM = 2'b00;
  localparam logic [1:0] MODE_PASS = 2'b01;
  localparam logic [1:0] MODE_LOCK = 2'b10;

  logic [SW-1:0]        r_slot;
  logic [DW-1:0]        r_digit;
  logic [BW-1:0]        r_bcnt;
  logic                 r_phase;
  logic                 r_pending;
  logic [4*DIGITS-1:0]  r_shd_data;
  logic [DIGITS-1:0]    r_shd_blank;
  logic [DIGITS-1:0]    r_shd_blink;
  logic [DIGITS-1:0]    r_shd_dp;
  logic [4*DIGITS-1:0]  r_act_data;
  logic [DIGITS-1:0]    r_act_blank;
  logic [DIGITS-1:0]    r_act_blink;
  logic [DIGITS-1:0]    r_act_dp;
  logic [7:0]           r_seg;
  logic [DIGITS-1:0]    r_cs;

  logic                 w_slot_last;
  logic                 w_digit_last;
  logic                 w_frame_top;
  logic                 w_frame_end;
  logic [3:0]           w_code;
  logic [7:0]           w_seg_nxt;
  logic [DIGITS-1:0]    w_cs_nxt;

  function automatic logic [6:0] f_decode(input logic [3:0] code);
    case (code)
      4'h0: f_decode = 7'h3F;
      4'h1: f_decode = 7'h06;
      4'h2: f_decode = 7'h5B;
      4'h3: f_decode = 7'h4F;
      4'h4: f_decode = 7'h66;
      4'h5: f_decode = 7'h6D;
      4'h6: f_decode = 7'h7D;
      4'h7: f_decode = 7'h07;
      4'h8: f_decode = 7'h7F;
      4'h9: f_decode = 7'h6F;
      4'hA: f_decode = 7'h73;  // P
      4'hB: f_decode = 7'h77;  // A
      4'hC: f_decode = 7'h6D;  // S
      4'hD: f_decode = 7'h40;  // dash
      default: f_decode = 7'h00;
    endcase
  endfunction

  assign w_slot_last  = (r_slot == SW'(SCAN_DIV - 1));
  assign w_digit_last = (r_digit == DW'(DIGITS - 1));
  assign w_frame_top  = (r_slot == '0) && (r_digit == '0);
  assign w_frame_end  = w_slot_last && w_digit_last;
  assign w_code       = r_act_data[4*r_digit +: 4];

  // Counters sit at zero throughout reset, so the first cycle with RST_N high
  // is already the top of frame 0.
  assign frame_start  = RST_N & w_frame_top;
  assign ready        = ~r_pending;
  assign seg          = r_seg;
  assign cs           = r_cs;

  always_comb begin
    w_seg_nxt = 8'h00;
    w_cs_nxt  = '1;
    if ((r_slot >= SW'(GUARD)) && (mode != 2'b11)) begin
      w_cs_nxt = ~(DIGITS'(1) << r_digit);
      case (mode)
        MODE_NORM: begin
          if (!r_act_blank[r_digit] && !(r_act_blink[r_digit] && r_phase))
            w_seg_nxt = {r_act_dp[r_digit], f_decode(w_code)};
        end
        MODE_PASS: begin
          // PASS reads left to right across the top four digits
          if (r_digit == DW'(DIGITS - 1))
            w_seg_nxt = 8'h73;
          else if (r_digit == DW'(DIGITS - 2))
            w_seg_nxt = 8'h77;
          else if ((r_digit == DW'(DIGITS - 3)) || (r_digit == DW'(DIGITS - 4)))
            w_seg_nxt = 8'h6D;
        end
        MODE_LOCK: w_seg_nxt = 8'h40;
        default:   w_seg_nxt = 8'h00;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_slot      <= '0;
      r_digit     <= '0;
      r_bcnt      <= '0;
      r_phase     <= 1'b0;
      r_pending   <= 1'b0;
      r_shd_data  <= '0;
      r_shd_blank <= '1;
      r_shd_blink <= '0;
      r_shd_dp    <= '0;
      r_act_data  <= '0;
      r_act_blank <= '1;
      r_act_blink <= '0;
      r_act_dp    <= '0;
      r_seg       <= 8'h00;
      r_cs        <= '1;
    end else begin
      if (w_slot_last) begin
        r_slot  <= '0;
        r_digit <= w_digit_last ? '0 : r_digit + 1'b1;
      end else begin
        r_slot  <= r_slot + 1'b1;
      end

      // The phase flips as a frame closes. Frames 0..BLINK_DIV-1 therefore
      // show phase 0, and the next BLINK_DIV frames show phase 1.
      if (w_frame_end) begin
        if (r_bcnt == BW'(BLINK_DIV - 1)) begin
          r_bcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_bcnt  <= r_bcnt + 1'b1;
        end
      end

      // The old shadow transfers before a coincident load overwrites it.
      if (w_frame_top) begin
        r_act_data  <= r_shd_data;
        r_act_blank <= r_shd_blank;
        r_act_blink <= r_shd_blink;
        r_act_dp    <= r_shd_dp;
      end

      if (load) begin
        r_shd_data  <= data;
        r_shd_blank <= blank_mask;
        r_shd_blink <= blink_mask;
        r_shd_dp    <= dp_mask;
        r_pending   <= 1'b1;
      end else if (w_frame_top) begin
        r_pending   <= 1'b0;
      end

      r_seg <= w_seg_nxt;
      r_cs  <= w_cs_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl. A behavioural model turns the cycle count
// since reset into slot, digit, frame and blink phase with plain arithmetic.
// It pushes the expected registered outputs for every cycle into a queue. A
// monitor on the falling edge pops each entry and compares it with the DUT.
module tb_seg7_scan_ctrl;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 8;
  localparam int GUARD     = 2;
  localparam int BLINK_DIV = 2;
  localparam int FRAME     = DIGITS * SCAN_DIV;

  logic                CLK = 1'b0;
  logic                RST_N;
  logic                load;
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   blank_mask, blink_mask, dp_mask;
  logic [1:0]          mode;
  logic                ready, frame_start;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   cs;

  seg7_scan_ctrl #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .load(load), .data(data),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .dp_mask(dp_mask),
    .mode(mode), .ready(ready), .frame_start(frame_start), .seg(seg), .cs(cs)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DIGITS-1:0] cs;
    logic [7:0]        seg;
    logic              ready;
    logic              top;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [6:0] m_dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h73, 7'h77, 7'h6D, 7'h40, 7'h00, 7'h00};
  logic [3:0] m_shd_code [DIGITS];
  logic [3:0] m_act_code [DIGITS];
  bit         m_shd_blank [DIGITS], m_shd_blink [DIGITS], m_shd_dp [DIGITS];
  bit         m_act_blank [DIGITS], m_act_blink [DIGITS], m_act_dp [DIGITS];
  bit         m_pending;
  int         m_t = 0;

  function automatic logic [7:0] model_seg(int d, bit ph, logic [1:0] md);
    int pos;
    pos = DIGITS - 1 - d;
    model_seg = 8'h00;
    if (md == 2'b00) begin
      if (!m_act_blank[d] && !(m_act_blink[d] && ph))
        model_seg = {m_act_dp[d], m_dec[m_act_code[d]]};
    end else if (md == 2'b01) begin
      if (pos == 0) model_seg = 8'h73;
      else if (pos == 1) model_seg = 8'h77;
      else if (pos == 2 || pos == 3) model_seg = 8'h6D;
    end else if (md == 2'b10) begin
      model_seg = 8'h40;
    end
  endfunction

  always @(posedge CLK) begin
    exp_t e;
    int d, s, f;
    bit ph;
    if (!RST_N) begin
      for (int i = 0; i < DIGITS; i++) begin
        m_shd_code[i] = 4'h0; m_act_code[i] = 4'h0;
        m_shd_blank[i] = 1'b1; m_act_blank[i] = 1'b1;
        m_shd_blink[i] = 1'b0; m_act_blink[i] = 1'b0;
        m_shd_dp[i] = 1'b0; m_act_dp[i] = 1'b0;
      end
      m_pending = 1'b0;
      m_t = 0;
      e.cs = '1; e.seg = 8'h00; e.ready = 1'b1; e.top = 1'b1;
    end else begin
      d  = (m_t / SCAN_DIV) % DIGITS;
      s  = m_t % SCAN_DIV;
      f  = m_t / FRAME;
      ph = ((f / BLINK_DIV) % 2) == 1;
      e.cs = '1; e.seg = 8'h00;
      if (s >= GUARD && mode != 2'b11) begin
        e.cs  = ~(DIGITS'(1) << d);
        e.seg = model_seg(d, ph, mode);
      end
      if (m_t % FRAME == 0) begin
        for (int i = 0; i < DIGITS; i++) begin
          m_act_code[i] = m_shd_code[i]; m_act_blank[i] = m_shd_blank[i];
          m_act_blink[i] = m_shd_blink[i]; m_act_dp[i] = m_shd_dp[i];
        end
        m_pending = 1'b0;
      end
      if (load) begin
        for (int i = 0; i < DIGITS; i++) begin
          m_shd_code[i] = data[4*i +: 4]; m_shd_blank[i] = blank_mask[i];
          m_shd_blink[i] = blink_mask[i]; m_shd_dp[i] = dp_mask[i];
        end
        m_pending = 1'b1;
      end
      m_t = m_t + 1;
      e.ready = !m_pending;
      e.top   = (m_t % FRAME) == 0;
    end
    q.push_back(e);
  end

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("cs", 8'(cs), 8'(e.cs));
      check("seg", seg, e.seg);
      check("ready", 8'(ready), 8'(e.ready));
      check("frame_start", 8'(frame_start), 8'(e.top && RST_N));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(logic [15:0] d, logic [3:0] bl, logic [3:0] bk, logic [3:0] dp);
    data = d; blank_mask = bl; blink_mask = bk; dp_mask = dp; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic align(int phase);
    for (int i = 0; i < 2*FRAME && (m_t % FRAME) != phase; i++) step();
  endtask

  initial begin
    RST_N = 1'b0; load = 1'b0; data = '0; mode = 2'b00;
    blank_mask = '0; blink_mask = '0; dp_mask = '0;
    repeat (3) step();
    RST_N = 1'b1;
    repeat (40) step();

    align(12);
    do_load(16'h9D21, 4'b0000, 4'b0000, 4'b0001);
    repeat (70) step();

    align(5);
    do_load(16'h1111, 4'b0000, 4'b0000, 4'b0000);
    repeat (6) step();
    do_load(16'h2222, 4'b0000, 4'b0000, 4'b0000);
    repeat (70) step();

    align(0);
    do_load(16'h8765, 4'b0000, 4'b0100, 4'b1010);
    repeat (8*FRAME) step();

    mode = 2'b01; repeat (40) step();
    mode = 2'b10; repeat (40) step();
    mode = 2'b11; repeat (40) step();
    mode = 2'b00; repeat (10) step();

    align(10);
    do_load(16'h4321, 4'b0000, 4'b0000, 4'b1111);
    step();
    RST_N = 1'b0; step(); RST_N = 1'b1;
    repeat (40) step();

    // randomized traffic: loads (some on the frame top), mode flips, resets
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        data = 16'($urandom); blank_mask = 4'($urandom_range(0, 15));
        blink_mask = 4'($urandom_range(0, 15)); dp_mask = 4'($urandom_range(0, 15));
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      RST_N = ($urandom_range(0, 299) != 0);
      step();
    end
    load = 1'b0; RST_N = 1'b1;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, number of multiplexed digits (range 4..8).
REQ-002 The block SHALL have parameter SCAN_DIV, default 50000, CLK cycles per digit slot (1 ms at 50 MHz).
REQ-003 The block SHALL have parameter GUARD, default 16, anti-ghosting cycles at the start of each slot (GUARD < SCAN_DIV).
REQ-004 The block SHALL have parameter BLINK_DIV, default 125, full frames per blink half-period.
REQ-005 The block SHALL have port CLK, input, 1, the only clock, with all logic on its rising edge.
REQ-006 The block SHALL have port RST_N, input, 1, synchronous active-low reset.
REQ-007 The block SHALL have port load, input, 1, a one-cycle strobe that captures data and masks into the shadow buffer.
REQ-008 The block SHALL have port data, input, 4*DIGITS, digit codes with nibble i driving digit i.
REQ-009 The block SHALL have ports blank_mask, blink_mask and dp_mask, each input, DIGITS wide, giving per-digit blank, blink and decimal-point enables.
REQ-010 The block SHALL have port mode, input, 2, where 00 is normal, 01 is PASS, 10 is lockout and 11 is off; mode is sampled every cycle and is not buffered.
REQ-011 The block SHALL have port ready, output, 1, which is high when no shadow transfer is pending.
REQ-012 The block SHALL have port frame_start, output, 1, a one-cycle pulse at the start of digit 0's slot.
REQ-013 The block SHALL have port seg, output, 8, active-high segments with bit7 as the decimal point.
REQ-014 The block SHALL have port cs, output, DIGITS, active-low digit selects.

Function
REQ-015 The slot counter SHALL count 0..SCAN_DIV-1 and the digit index SHALL count 0..DIGITS-1, wrapping both to 0; the digit index advances when the slot counter wraps.
REQ-016 For slot counts below GUARD, cs SHALL be all ones and seg SHALL be 0x00; otherwise exactly one cs bit (that of the digit index) SHALL be 0.
REQ-017 On load, the shadow buffer SHALL capture data and all three masks on that edge, and ready SHALL be 0 from the next cycle.
REQ-018 A load while ready is 0 SHALL overwrite the shadow buffer, keeping the last load.
REQ-019 Shadow-to-active transfer SHALL happen only on the cycle where the digit index is 0 and the slot counter is 0, which is the same cycle frame_start pulses; ready SHALL be 1 from that cycle on.
REQ-020 If load coincides with the transfer cycle, the old shadow SHALL transfer, the new values SHALL be captured, and ready SHALL stay 0 until the next frame.
REQ-021 Code decoding SHALL be: 0..9 map to 3F,06,5B,4F,66,6D,7D,07,7F,6F; A maps to 73 (P); B to 77 (A); C to 6D (S); D to 40 (dash); E and F to 00 (blank).
REQ-022 In normal mode, seg[6:0] SHALL be the decode of the active digit's code and seg[7] SHALL be its dp_mask bit.
REQ-023 In normal mode, an active blank_mask bit SHALL force seg to 00.
REQ-024 In normal mode, an active blink_mask bit SHALL force seg to 00 while the blink phase is 1.
REQ-025 The blink phase SHALL toggle after every BLINK_DIV frame_start pulses, with its frame counter counting 0..BLINK_DIV-1.
REQ-026 PASS mode SHALL show P,A,S,S on digits DIGITS-1 down to DIGITS-4, with all other digits 00 and dp off.
REQ-027 Lockout mode SHALL show 40 on every digit, ignoring all masks.
REQ-028 Off mode SHALL hold cs all ones and seg at 00, while counters and the handshake keep running.
REQ-029 A mode change SHALL take effect on the next cycle with no frame realignment.
REQ-030 seg and cs SHALL be registered, and both SHALL reflect state from the previous cycle.

Reset
REQ-031 While RST_N is 0 at a rising edge: both counters 0, blink phase 0, blink frame counter 0, cs all ones, seg 00, frame_start 0, ready 1.
REQ-032 While RST_N is 0 at a rising edge: active and shadow codes 0, blank_mask all ones, blink and dp masks 0, so the display is dark until the first transfer.
REQ-033 Reset asserted mid-frame or with a transfer pending SHALL discard the pending shadow, set ready to 1, and restart at digit 0.
REQ-034 The first frame_start after reset release SHALL occur on the first cycle with RST_N 1.

Verification
REQ-035 All scenarios SHALL use DIGITS=4, SCAN_DIV=8, GUARD=2, BLINK_DIV=2.
REQ-036 Release reset with no load -> frame_start every 32 cycles; cs walks 1110,1101,1011,0111; each slot is 2 cycles of cs=1111 then 6 cycles of the digit; seg stays 00.
REQ-037 Mid-frame load with data=0x9D21, blank_mask=0, dp_mask=0001 -> ready=0 until the next frame_start; next frame gives seg 86,5B,40,6F on digits 0..3.
REQ-038 Two loads in the same frame (0x1111, then 0x2222) -> the next frame shows all 5B, and 0x1111 never appears.
REQ-039 blink_mask=0100 with data loaded -> digit 2 dark in frames 2,3,6,7 and lit in frames 0,1,4,5; other digits always lit.
REQ-040 Mode sequence 01, 10, 11 -> PASS gives digit3..0 = 73,77,6D,6D; lockout gives 40 on all digits; off gives cs held at 1111 while frame_start keeps pulsing.
REQ-041 Load, then RST_N low for 1 cycle before the transfer -> ready=1, cs=1111, display dark; the prior shadow never transfers.
